// File: rtl/sprite_lbuf_writer.sv
`default_nettype none
// =============================================================================
// Module : sprite_lbuf_writer
// Merges one 16-pixel 4bpp sprite row into the 256-pixel line-buffer RAM by
// read-modify-write, with pixel value 0 transparent. Optional build macro
// SPR_FIRST_WINS_EN: existing non-zero pixels win over later sprites.
// Rev    : 1.0
// =============================================================================

module sprite_lbuf_writer (
  input  logic        CK1,
  input  logic        RESET,
  input  logic        CEN,
  input  logic        SPR_VALID,
  output logic        SPR_READY,
  input  logic [7:0]  SPR_X,
  input  logic        SPR_FLIPX,
  input  logic [63:0] SPR_DATA,
  output logic [6:0]  LB_ADDR,
  input  logic [7:0]  LB_DIN,
  output logic [7:0]  LB_DOUT,
  output logic        LB_WE,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  addr_q,  addr_d;
  logic [6:0]  last_q,  last_d;
  logic [7:0]  x_q,     x_d;
  logic        flip_q,  flip_d;
  logic [63:0] data_q,  data_d;
  logic        ready_q, ready_d;
  logic        busy_q,  busy_d;

  logic [7:0]  span_end;
  logic [7:0]  merged;

  // (x + 15) >> 1 rewritten as x[7:1] + 7 + x[0]; bit 7 set means past byte 127
  assign span_end = {1'b0, SPR_X[7:1]} + 8'd7 + {7'd0, SPR_X[0]};

  generate
    for (genvar n = 0; n < 2; n++) begin : g_nib
      logic [8:0] off;
      logic       hit;
      logic [3:0] idx;
      logic [3:0] pix;
      logic [3:0] old;
      logic       take;

      assign off = {1'b0, addr_q, (n == 1) ? 1'b1 : 1'b0} - {1'b0, x_q};
      assign hit = (off < 9'd16);
      assign idx = flip_q ? (4'd15 - off[3:0]) : off[3:0];
      assign pix = data_q[{idx, 2'b00} +: 4];
      assign old = LB_DIN[4*n +: 4];
`ifdef SPR_FIRST_WINS_EN
      assign take = hit && (pix != 4'h0) && (old == 4'h0);
`else
      assign take = hit && (pix != 4'h0);
`endif
      assign merged[4*n +: 4] = take ? pix : old;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    x_d     = x_q;
    flip_d  = flip_q;
    data_d  = data_q;

    if (CEN) begin
      case (state_q)
        ST_IDLE: begin
          if (SPR_VALID) begin
            x_d     = SPR_X;
            flip_d  = SPR_FLIPX;
            data_d  = SPR_DATA;
            addr_d  = SPR_X[7:1];
            last_d  = span_end[7] ? 7'h7F : span_end[6:0];
            state_d = ST_RD;
          end
        end
        ST_RD: begin
          state_d = ST_WR;
        end
        ST_WR: begin
          if (addr_q == last_q) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + 7'd1;
            state_d = ST_RD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge CK1) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= 7'd0;
      last_q  <= 7'd0;
      x_q     <= 8'd0;
      flip_q  <= 1'b0;
      data_q  <= 64'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      x_q     <= x_d;
      flip_q  <= flip_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // RAM read data is only meaningful in WR, so the write path is combinational
  assign LB_ADDR   = addr_q;
  assign LB_DOUT   = (state_q == ST_WR) ? merged : 8'h00;
  assign LB_WE     = (state_q == ST_WR) && CEN;
  assign SPR_READY = ready_q;
  assign BUSY      = busy_q;

endmodule

`default_nettype wire
